// File: rtl/core_types_pkg.sv
// Shared pipeline types for the memory stage: stage bundles, FSM states, func3 encodings
// and the byte-lane helpers used to build store requests.
package core_types_pkg;

  typedef struct packed {
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
    logic [2:0]  func3;
  } EXE_out_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        Wreg;
  } MEM_out_t;

  typedef enum logic [0:0] {IDLE, WAIT_R} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_gen(input logic [2:0] func3, input logic [1:0] a);
    logic [3:0] be;
    case (func3[1:0])
      F3_B[1:0]: be = 4'b0001 << a;
      F3_H[1:0]: be = 4'b0011 << {a[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] wdata_gen(input logic [2:0] func3, input logic [31:0] rs2);
    logic [31:0] wd;
    case (func3[1:0])
      F3_B[1:0]: wd = {4{rs2[7:0]}};
      F3_H[1:0]: wd = {2{rs2[15:0]}};
      default:   wd = rs2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed byte/halfword lane and sign- or zero-extends it.
module mem_load_align
  import core_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  a,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte = 8'h00;
    unique case (a)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = a[1] ? rdata[31:16] : rdata[15:0];
  assign w_sext = ~func3[2];

  always_comb begin
    case (func3[1:0])
      F3_B[1:0]: data = {{24{w_sext & w_byte[7]}}, w_byte};
      F3_H[1:0]: data = {{16{w_sext & w_half[15]}}, w_half};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage over a req/gnt/rvalid data bus.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are dropped and flagged.
module mem_stage
  import core_types_pkg::*;
#(
  parameter int unsigned RVALID_TIMEOUT = 0
) (
  input  logic        Clock,
  input  logic        nReset,
  input  EXE_out_t    ex_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output MEM_out_t    MEM_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        mem_misalign,
`endif
  output logic        mem_bus_err
);

  mem_state_t  r_state;
  logic [31:0] r_cnt;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;
  logic [1:0]  r_a;
  logic        r_wreg;

  logic        w_mem_op;
  logic        w_misalign;
  logic        w_timeout;
  logic [31:0] w_load_data;

  assign w_mem_op = ex_in.Wmem | ex_in.Rmem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op &&
                      (((ex_in.func3[1:0] == F3_H[1:0]) && ex_in.result[0]) ||
                       (ex_in.func3[1] && (ex_in.result[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout = (RVALID_TIMEOUT != 0) && (r_state == WAIT_R) && !dmem_rvalid &&
                     (r_cnt == RVALID_TIMEOUT - 1);

  assign dmem_addr  = {ex_in.result[31:2], 2'b00};
  assign dmem_be    = be_gen(ex_in.func3, ex_in.result[1:0]);
  assign dmem_wdata = wdata_gen(ex_in.func3, ex_in.rs2);

  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    stall    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op && !w_misalign) begin
          dmem_req = 1'b1;
          dmem_we  = ex_in.Wmem;
          // A granted load still stalls: its data arrives in WAIT_R.
          stall    = ex_in.Wmem ? !dmem_gnt : 1'b1;
        end
      end
      WAIT_R: stall = !dmem_rvalid && !w_timeout;
    endcase
  end

  mem_load_align u_load_align (
    .rdata (dmem_rdata),
    .func3 (r_f3),
    .a     (r_a),
    .data  (w_load_data)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_f3        <= '0;
      r_a         <= '0;
      r_wreg      <= 1'b0;
      MEM_out     <= '0;
      mem_bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign <= 1'b0;
`endif
    end else begin
      mem_bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign <= w_misalign && (r_state == IDLE);
`endif
      unique case (r_state)
        IDLE: begin
          if (w_misalign) begin
            MEM_out.Wreg <= 1'b0;
          end else if (ex_in.Wmem) begin
            if (dmem_gnt) MEM_out <= '{ex_in.rd, ex_in.result, 1'b0};
            else          MEM_out.Wreg <= 1'b0;
          end else if (ex_in.Rmem) begin
            MEM_out.Wreg <= 1'b0;
            if (dmem_gnt) begin
              r_rd    <= ex_in.rd;
              r_f3    <= ex_in.func3;
              r_a     <= ex_in.result[1:0];
              r_wreg  <= ex_in.Wreg;
              r_cnt   <= '0;
              r_state <= WAIT_R;
            end
          end else begin
            MEM_out <= '{ex_in.rd, ex_in.result, ex_in.Wreg};
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            MEM_out <= '{r_rd, w_load_data, r_wreg};
            r_state <= IDLE;
          end else if (w_timeout) begin
            MEM_out     <= '{r_rd, 32'h0, 1'b0};
            mem_bus_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            MEM_out.Wreg <= 1'b0;
            r_cnt        <= r_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected writeback bundles plus bus-side checks.
module tb_mem_stage;
  import core_types_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  EXE_out_t    ex_in = '0;
  logic        dmem_req, dmem_we, stall, mem_bus_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  MEM_out_t    MEM_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  MEM_out_t exp_q[$];

  always #5 Clock = ~Clock;

  mem_stage #(.RVALID_TIMEOUT(4)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .ex_in       (ex_in),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall       (stall),
    .MEM_out     (MEM_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misalign(mem_misalign),
`endif
    .mem_bus_err (mem_bus_err)
  );

  function automatic EXE_out_t op(input logic [4:0] rd, input logic [31:0] result,
                                  input logic [31:0] rs2, input logic [2:0] f3,
                                  input logic wmem, input logic rmem, input logic wreg);
    EXE_out_t e;
    e.rd = rd; e.result = result; e.rs2 = rs2; e.func3 = f3;
    e.Wmem = wmem; e.Rmem = rmem; e.Wreg = wreg;
    return e;
  endfunction

  function automatic MEM_out_t mo(input logic [4:0] rd, input logic [31:0] d, input logic w);
    MEM_out_t m;
    m.rd = rd; m.data = d; m.Wreg = w;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    MEM_out_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got rd=%0d data=0x%0h Wreg=%0b", tag,
             MEM_out.rd, MEM_out.data, MEM_out.Wreg);
    end else begin
      e = exp_q.pop_front();
      assert (MEM_out === e) else begin
        n_fail++;
        $error("FAIL %s: got rd=%0d data=0x%0h Wreg=%0b expected rd=%0d data=0x%0h Wreg=%0b",
               tag, MEM_out.rd, MEM_out.data, MEM_out.Wreg, e.rd, e.data, e.Wreg);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge Clock);
  endtask

  task automatic after_edge();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) at_neg();
    chk("rst_memout", 64'(MEM_out), 64'h0);
    chk("rst_buserr", 64'(mem_bus_err), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_req", 64'(dmem_req), 64'h0);
    nReset = 1'b1;

    // ALU pass-through
    at_neg();
    ex_in = op(5'd5, 32'h1234, 32'h0, F3_W, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mo(5'd5, 32'h1234, 1'b1));
    #1;
    chk("alu_stall", 64'(stall), 64'h0);
    chk("alu_req", 64'(dmem_req), 64'h0);
    after_edge();
    chk_mem("alu_memout");

    // Store byte at 0x1003, grant held off for two cycles
    at_neg();
    ex_in = op(5'd7, 32'h1003, 32'hAB, F3_B, 1'b1, 1'b0, 1'b1);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("sb_req", 64'(dmem_req), 64'h1);
      chk("sb_we", 64'(dmem_we), 64'h1);
      chk("sb_addr", 64'(dmem_addr), 64'h1000);
      chk("sb_be", 64'(dmem_be), 64'h8);
      chk("sb_wdata", 64'(dmem_wdata), 64'hABABABAB);
      chk("sb_stall", 64'(stall), 64'h1);
      after_edge();
      chk("sb_bubble_wreg", 64'(MEM_out.Wreg), 64'h0);
      at_neg();
    end
    dmem_gnt = 1'b1;
    exp_q.push_back(mo(5'd7, 32'h1003, 1'b0));
    #1;
    chk("sb_gnt_stall", 64'(stall), 64'h0);
    after_edge();
    chk_mem("sb_memout");

    // Store half at 0x1006 with Rmem also set: Wmem wins
    at_neg();
    ex_in = op(5'd8, 32'h1006, 32'h1234ABCD, F3_H, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(mo(5'd8, 32'h1006, 1'b0));
    #1;
    chk("sh_we", 64'(dmem_we), 64'h1);
    chk("sh_be", 64'(dmem_be), 64'hC);
    chk("sh_wdata", 64'(dmem_wdata), 64'hABCDABCD);
    chk("sh_stall", 64'(stall), 64'h0);
    after_edge();
    chk_mem("sh_memout");

    // LB at 0x2001, immediate grant, rvalid on the third WAIT_R cycle
    at_neg();
    ex_in = op(5'd9, 32'h2001, 32'h0, F3_B, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    dmem_rdata = 32'h0000_8000;
    exp_q.push_back(mo(5'd9, 32'hFFFF_FF80, 1'b1));
    #1;
    chk("lb_req", 64'(dmem_req), 64'h1);
    chk("lb_we", 64'(dmem_we), 64'h0);
    chk("lb_be", 64'(dmem_be), 64'h2);
    chk("lb_stall", 64'(stall), 64'h1);
    after_edge();
    chk("lb_bubble0", 64'(MEM_out.Wreg), 64'h0);
    for (int i = 0; i < 2; i++) begin
      at_neg();
      dmem_gnt = 1'b0;
      #1;
      chk("lb_wait_stall", 64'(stall), 64'h1);
      chk("lb_wait_req", 64'(dmem_req), 64'h0);
      after_edge();
      chk("lb_wait_wreg", 64'(MEM_out.Wreg), 64'h0);
    end
    at_neg();
    dmem_rvalid = 1'b1;
    #1;
    chk("lb_rvalid_stall", 64'(stall), 64'h0);
    after_edge();
    chk_mem("lb_memout");

    // LHU at 0x2002, rvalid on the first WAIT_R cycle
    at_neg();
    dmem_rvalid = 1'b0;
    ex_in = op(5'd10, 32'h2002, 32'h0, F3_HU, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    dmem_rdata = 32'hBEEF_0000;
    exp_q.push_back(mo(5'd10, 32'h0000_BEEF, 1'b1));
    #1;
    chk("lhu_be", 64'(dmem_be), 64'hC);
    after_edge();
    at_neg();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    after_edge();
    chk_mem("lhu_memout");

    // LW with no rvalid: times out after four WAIT_R cycles
    at_neg();
    dmem_rvalid = 1'b0;
    ex_in = op(5'd11, 32'h3000, 32'h0, F3_W, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    after_edge();
    at_neg();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_wait_stall", 64'(stall), 64'h1);
      chk("to_wait_err", 64'(mem_bus_err), 64'h0);
      at_neg();
    end
    #1;
    chk("to_final_stall", 64'(stall), 64'h0);
    exp_q.push_back(mo(5'd11, 32'h0, 1'b0));
    after_edge();
    chk_mem("to_memout");
    chk("to_err_pulse", 64'(mem_bus_err), 64'h1);

    // Late rvalid in IDLE is ignored; ALU op flows through
    at_neg();
    ex_in = op(5'd12, 32'h55, 32'h0, F3_W, 1'b0, 1'b0, 1'b1);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(mo(5'd12, 32'h55, 1'b1));
    #1;
    chk("late_stall", 64'(stall), 64'h0);
    after_edge();
    chk_mem("late_memout");
    chk("late_err_clear", 64'(mem_bus_err), 64'h0);

    // Reset asserted while in WAIT_R
    at_neg();
    dmem_rvalid = 1'b0;
    ex_in = op(5'd13, 32'h4000, 32'h0, F3_W, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b1;
    after_edge();
    at_neg();
    dmem_gnt = 1'b0;
    #1;
    chk("rstw_stall_before", 64'(stall), 64'h1);
    #2;
    nReset = 1'b0;
    ex_in = '0;
    #1;
    chk("rstw_memout", 64'(MEM_out), 64'h0);
    chk("rstw_stall", 64'(stall), 64'h0);
    chk("rstw_req", 64'(dmem_req), 64'h0);
    at_neg();
    nReset = 1'b1;
    ex_in = op(5'd14, 32'h77, 32'h0, F3_W, 1'b0, 1'b0, 1'b1);
    dmem_rvalid = 1'b1;
    exp_q.push_back(mo(5'd14, 32'h77, 1'b1));
    after_edge();
    chk_mem("rstw_after_memout");
    at_neg();
    dmem_rvalid = 1'b0;

    // LW at 0x2002: trapped when the misalign feature is on, word-aligned otherwise
    ex_in = op(5'd15, 32'h2002, 32'h0, F3_W, 1'b0, 1'b1, 1'b1);
    dmem_gnt = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    chk("mis_req", 64'(dmem_req), 64'h0);
    chk("mis_stall", 64'(stall), 64'h0);
    after_edge();
    chk("mis_wreg", 64'(MEM_out.Wreg), 64'h0);
    chk("mis_pulse", 64'(mem_misalign), 64'h1);
    at_neg();
    ex_in = '0;
    after_edge();
    chk("mis_pulse_end", 64'(mem_misalign), 64'h0);
`else
    #1;
    chk("lw_req", 64'(dmem_req), 64'h1);
    chk("lw_addr", 64'(dmem_addr), 64'h2000);
    chk("lw_be", 64'(dmem_be), 64'hF);
    at_neg();
    ex_in = '0;
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the registered EXE-stage bundle (EXE_out_t), performs loads and stores over a req/gnt/rvalid data-memory interface, and registers the writeback bundle (MEM_out_t) for the WB stage.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- RVALID_TIMEOUT, 0, maximum cycles to wait for dmem_rvalid in WAIT_R. 0 disables the timeout.

Ports:
- Clock  input  1  clock
- nReset  input  1  asynchronous active-low reset
- ex_in  input  EXE_out_t  rs2[31:0], rd[4:0], result[31:0], Wmem, Rmem, Wreg, func3[2:0]
- dmem_req  output  1  request valid
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address {result[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  load data valid
- dmem_rdata  input  32  load data
- stall  output  1  hold upstream stages
- MEM_out  output  MEM_out_t  rd[4:0], data[31:0], Wreg
- mem_bus_err  output  1  registered one-cycle pulse on load timeout

Behaviour:
- Reset is asynchronous, active-low on nReset; clock is Clock.
- Reset values: MEM_out all 0; mem_bus_err 0; state IDLE; timeout counter 0.
- dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata and stall are combinational from ex_in and state.
- FSM states: IDLE, WAIT_R.
- IDLE with Wmem=Rmem=0:
  - No request.
  - Next edge: MEM_out <= {ex_in.rd, ex_in.result, ex_in.Wreg}.
  - Latency 1 cycle; stall=0.
- IDLE with Wmem=1 (Rmem ignored when Wmem=1):
  - dmem_req=1, dmem_we=1.
  - If dmem_gnt: store completes; next edge MEM_out <= {rd, result, Wreg=0}; stall=0.
  - If !dmem_gnt: stall=1; next edge MEM_out.Wreg <= 0 (bubble). ex_in is held stable by upstream.
- IDLE with Rmem=1:
  - dmem_req=1, dmem_we=0.
  - If !dmem_gnt: stall=1; bubble into MEM_out.
  - If dmem_gnt: stall=1; latch rd, func3, addr[1:0], Wreg; go to WAIT_R; bubble into MEM_out.
- WAIT_R:
  - dmem_req=0.
  - If !dmem_rvalid: stall=1; bubble.
  - If dmem_rvalid: stall=0; next edge MEM_out <= {latched rd, formatted load data, latched Wreg}; go to IDLE.
  - A new op presented that same cycle is not issued until the following cycle.
- Timeout (RVALID_TIMEOUT=N>0):
  - Counter increments each WAIT_R cycle without rvalid; it is cleared on entry to WAIT_R.
  - On reaching N: complete the load with data 0 and Wreg=0; pulse mem_bus_err; go to IDLE; stall=0.
  - A late rvalid arriving in IDLE is ignored.
- Byte enables by func3[1:0]:
  - 00 (byte): 4'b0001<<a[1:0]
  - 01 (half): 4'b0011<<{a[1],1'b0}
  - 10 (word): 4'b1111
  - 11: treated as word.
- Store data: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2.
- Load formatting:
  - Select byte lane a[1:0], or halfword at a[1].
  - func3[2]=0 sign-extends (LB, LH); func3[2]=1 zero-extends (LBU, LHU); word passes through.
- Reset mid-transaction: immediate return to IDLE. Any outstanding rvalid after reset is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with a[0]=1, or a word access with a[1:0]!=0, issues no dmem_req and has stall=0.
  - Next edge: MEM_out.Wreg <= 0, and the output port mem_misalign (1 bit, reset 0) pulses for one cycle.
- Undefined:
  - Port mem_misalign absent.
  - Low address bits are ignored beyond the lane rules above; a half access uses a[1] only, a word access ignores a[1:0].

Decomposition:
- core_types_pkg:
  - MEM_out_t struct.
  - mem_state_t enum {IDLE, WAIT_R}.
  - func3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module mem_load_align (combinational): inputs rdata, func3, a[1:0]; output 32-bit formatted data.

Test Plan:
- ALU pass-through: ex_in {rd=5, result=0x1234, Wreg=1, Wmem=Rmem=0} -> after 1 edge, MEM_out={5, 0x1234, 1}; stall never high.
- Store byte, gnt delayed 2 cycles: result=0x1003, rs2=0xAB, func3=000 -> dmem_be=4'b1000, dmem_wdata=0xABABABAB, stall=1 for 2 cycles, MEM_out.Wreg=0 throughout.
- Load LB with sign extension: addr 0x2001, rdata=0x0000_8000, gnt immediate, rvalid 3 cycles later -> MEM_out.data=0xFFFFFF80, rd preserved, stall drops in the rvalid cycle.
- LHU: addr 0x2002, rdata=0xBEEF_0000 -> data=0x0000BEEF.
- Timeout, RVALID_TIMEOUT=4, no rvalid -> after 4 WAIT_R cycles, mem_bus_err pulses, Wreg=0, state IDLE.
- nReset asserted in WAIT_R -> MEM_out=0, stall=0, dmem_req=0. With MEM_MISALIGN_TRAP_EN, LW at 0x2002 -> no dmem_req, mem_misalign pulses.
